// File: rtl/clint_io_responder.sv
// Machine-timer / software-interrupt responder for the internal MMIO window.
// Single-outstanding valid/ready responder: accept in IDLE, hold response in RESP.
module clint_io_responder #(
  parameter logic [31:0] MSIP_ADDR     = 32'h0200_0000,
  parameter logic [31:0] MTIME_ADDR    = 32'h0200_1000,
  parameter logic [31:0] MTIMECMP_ADDR = 32'h0200_2000,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        msip_irq,
  output logic        mtip_irq,
  output logic [63:0] mtime_out
);

  typedef enum logic {IDLE, RESP} state_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  state_t      state_q, state_d;
  rsp_t        rsp_q, rsp_d;
  logic        msip_q;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q;
  logic [15:0] presc_q;
  logic        mtip_q;

  logic accept, word_ok, hit, wr_hit, tick;
  logic sel_msip, sel_mt_lo, sel_mt_hi, sel_cmp_lo, sel_cmp_hi;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    merge_be = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge_be[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  // FSM
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;

  // req_ready is gated by reset so it drops the instant reset asserts
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~reset_in;
        if (req_valid && !reset_in) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;

  // decode
  assign word_ok    = (req_addr[1:0] == 2'b00);
  assign sel_msip   = word_ok && (req_addr == MSIP_ADDR);
  assign sel_mt_lo  = word_ok && (req_addr == MTIME_ADDR);
  assign sel_mt_hi  = word_ok && (req_addr == MTIME_ADDR + 32'd4);
  assign sel_cmp_lo = word_ok && (req_addr == MTIMECMP_ADDR);
  assign sel_cmp_hi = word_ok && (req_addr == MTIMECMP_ADDR + 32'd4);
  assign hit        = sel_msip | sel_mt_lo | sel_mt_hi | sel_cmp_lo | sel_cmp_hi;
  assign wr_hit     = accept & req_wr & hit;

  assign tick = (presc_q == 16'(TICK_DIV - 1));

  // read data reflects register values before this edge's update
  always_comb begin
    rsp_d.err   = ~hit;
    rsp_d.rdata = 32'h0;
    if (!req_wr) begin
      if (sel_msip)   rsp_d.rdata = {31'b0, msip_q};
      if (sel_mt_lo)  rsp_d.rdata = mtime_q[31:0];
      if (sel_mt_hi)  rsp_d.rdata = mtime_q[63:32];
      if (sel_cmp_lo) rsp_d.rdata = mtimecmp_q[31:0];
      if (sel_cmp_hi) rsp_d.rdata = mtimecmp_q[63:32];
    end
  end

  // an MTIME store overrides the tick increment for that edge
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_hit && sel_mt_lo) mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], req_wdata, req_be)};
    if (wr_hit && sel_mt_hi) mtime_d = {merge_be(mtime_q[63:32], req_wdata, req_be), mtime_q[31:0]};
  end

  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      rsp_q      <= '0;
      msip_q     <= 1'b0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= '1;
      presc_q    <= 16'h0;
      mtip_q     <= 1'b0;
    end else begin
      if (accept) rsp_q <= rsp_d;
      presc_q <= tick ? 16'h0 : presc_q + 16'd1;
      mtime_q <= mtime_d;
      mtip_q  <= (mtime_q >= mtimecmp_q);
      if (wr_hit && sel_msip && req_be[0]) msip_q <= req_wdata[0];
      if (wr_hit && sel_cmp_lo) mtimecmp_q[31:0]  <= merge_be(mtimecmp_q[31:0], req_wdata, req_be);
      if (wr_hit && sel_cmp_hi) mtimecmp_q[63:32] <= merge_be(mtimecmp_q[63:32], req_wdata, req_be);
    end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign msip_irq  = msip_q;
  assign mtip_irq  = mtip_q;
  assign mtime_out = mtime_q;

endmodule

// File: tb/tb_clint_io_responder.sv
// Scoreboard bench for clint_io_responder: reference model predicts responses,
// interrupt lines and mtime; a second instance checks TICK_DIV=4 counting.
module tb_clint_io_responder;

  localparam logic [31:0] A_MSIP = 32'h0200_0000;
  localparam logic [31:0] A_MT   = 32'h0200_1000;
  localparam logic [31:0] A_CMP  = 32'h0200_2000;
  localparam int          TD     = 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_ready, rsp_valid, rsp_err, msip_irq, mtip_irq;
  logic [31:0] rsp_rdata;
  logic [63:0] mtime_out;
  logic        d4_req_ready, d4_rsp_valid, d4_rsp_err, d4_msip, d4_mtip;
  logic [31:0] d4_rdata;
  logic [63:0] d4_mtime;

  always #5 clk = ~clk;

  clint_io_responder #(.TICK_DIV(1)) dut (
    .clk_in(clk), .reset_in(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .msip_irq(msip_irq), .mtip_irq(mtip_irq),
    .mtime_out(mtime_out));

  clint_io_responder #(.TICK_DIV(4)) u_div4 (
    .clk_in(clk), .reset_in(rst),
    .req_valid(1'b0), .req_ready(d4_req_ready), .req_addr(32'h0),
    .req_wr(1'b0), .req_be(4'h0), .req_wdata(32'h0),
    .rsp_valid(d4_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(d4_rdata),
    .rsp_err(d4_rsp_err), .msip_irq(d4_msip), .mtip_irq(d4_mtip),
    .mtime_out(d4_mtime));

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // reference model state
  logic        m_busy = 1'b0, m_msip = 1'b0, m_mtip = 1'b0;
  logic [63:0] m_mtime = 64'h0, m_cmp = '1;
  int          m_presc = 0;
  longint      m4_cnt = 0;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic exp_t f_resp(input logic [31:0] a, input logic w);
    exp_t e;
    e.err = 1'b0;
    e.rdata = 32'h0;
    if      (a == A_MSIP)        e.rdata = {31'b0, m_msip};
    else if (a == A_MT)          e.rdata = m_mtime[31:0];
    else if (a == A_MT + 32'd4)  e.rdata = m_mtime[63:32];
    else if (a == A_CMP)         e.rdata = m_cmp[31:0];
    else if (a == A_CMP + 32'd4) e.rdata = m_cmp[63:32];
    else                         e.err = 1'b1;
    if (w) e.rdata = 32'h0;
    return e;
  endfunction

  function automatic logic [63:0] f_mtime_next();
    logic acc;
    acc = !m_busy && req_valid && req_wr;
    if (acc && req_addr == A_MT)         return {m_mtime[63:32], mrg(m_mtime[31:0], req_wdata, req_be)};
    if (acc && req_addr == A_MT + 32'd4) return {mrg(m_mtime[63:32], req_wdata, req_be), m_mtime[31:0]};
    return (m_presc == TD - 1) ? m_mtime + 64'd1 : m_mtime;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_msip  <= 1'b0;
      m_mtip  <= 1'b0;
      m_mtime <= 64'h0;
      m_cmp   <= '1;
      m_presc <= 0;
      m4_cnt  <= 0;
      sb.delete();
    end else begin
      m4_cnt  <= m4_cnt + 1;
      m_mtip  <= (m_mtime >= m_cmp);
      m_presc <= (m_presc == TD - 1) ? 0 : m_presc + 1;
      m_mtime <= f_mtime_next();
      if (!m_busy && req_valid) begin
        m_busy <= 1'b1;
        sb.push_back(f_resp(req_addr, req_wr));
        if (req_wr) begin
          if (req_addr == A_MSIP && req_be[0]) m_msip <= req_wdata[0];
          if (req_addr == A_CMP)         m_cmp[31:0]  <= mrg(m_cmp[31:0], req_wdata, req_be);
          if (req_addr == A_CMP + 32'd4) m_cmp[63:32] <= mrg(m_cmp[63:32], req_wdata, req_be);
        end
      end else if (m_busy && rsp_ready) begin
        m_busy <= 1'b0;
      end
    end
  end

  // every cycle out of reset: handshake, irq lines, mtime, and the response head
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_busy);
      chk("msip_irq", msip_irq, m_msip);
      chk("mtip_irq", mtip_irq, m_mtip);
      chk("mtime_out", mtime_out, m_mtime);
      chk("mtime_div4", d4_mtime, 64'(m4_cnt / 4));
      if (rsp_valid) begin
        if (sb.size() == 0) chk("sb_depth", 64'(sb.size()), 64'd1);
        else begin
          chk("rsp_rdata", rsp_rdata, sb[0].rdata);
          chk("rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // returns on the negedge right after the acceptance edge
  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
    int g = 0;
    @(negedge clk);
    while (m_busy && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("req_timeout", 64'(g), 64'd0);
    req_valid = 1'b1; req_addr = a; req_wr = w; req_be = be; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_err"}, rsp_err, 1'b0);
    chk({tag, "_msip"}, msip_irq, 1'b0);
    chk({tag, "_mtip"}, mtip_irq, 1'b0);
    chk({tag, "_mtime"}, mtime_out, 64'h0);
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(negedge clk) rst = 1'b0;

    // 1: MTIME read after ~10 cycles
    repeat (9) @(negedge clk);
    req(A_MT, 1'b0, 4'h0, 32'h0);

    // 2: compare match and release
    req(A_CMP + 32'd4, 1'b1, 4'hF, 32'h0);
    req(A_CMP, 1'b1, 4'hF, 32'h20);
    g = 0;
    while (mtime_out != 64'h20 && g < 200) begin @(negedge clk); g++; end
    chk("mt_reach20", mtime_out, 64'h20);
    chk("mtip_before", mtip_irq, 1'b0);
    @(negedge clk);
    chk("mtip_rise", mtip_irq, 1'b1);
    req(A_CMP + 32'd4, 1'b1, 4'hF, 32'h1);
    chk("mtip_hold", mtip_irq, 1'b1);
    @(negedge clk);
    chk("mtip_fall", mtip_irq, 1'b0);

    // 3: carry into high word, then full wrap
    req(A_MT + 32'd4, 1'b1, 4'hF, 32'h0);
    req(A_MT, 1'b1, 4'hF, 32'hFFFF_FFFF);
    chk("mt_lo_ones", mtime_out, 64'h0000_0000_FFFF_FFFF);
    req(A_MT + 32'd4, 1'b0, 4'h0, 32'h0);
    req(A_MT, 1'b0, 4'h0, 32'h0);
    req(A_MT + 32'd4, 1'b1, 4'hF, 32'hFFFF_FFFF);
    req(A_MT, 1'b1, 4'hF, 32'hFFFF_FFFF);
    chk("mt_all_ones", mtime_out, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("mt_wrap", mtime_out, 64'h0);

    // 4: MSIP byte enables
    req(A_MSIP, 1'b1, 4'b1110, 32'hFFFF_FFFF);
    chk("msip_be_hi", msip_irq, 1'b0);
    req(A_MSIP, 1'b1, 4'b0001, 32'hFFFF_FFFF);
    chk("msip_be_lo", msip_irq, 1'b1);
    req(A_MSIP, 1'b0, 4'h0, 32'h0);
    req(A_MSIP, 1'b1, 4'h0, 32'h0);

    // 5: faults and backpressure
    req(32'h0200_0002, 1'b0, 4'h0, 32'h0);
    req(32'h0200_3000, 1'b1, 4'hF, 32'h1234);
    req(32'h0200_0004, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1 rsp_ready = 1'b0;
    req(A_CMP, 1'b0, 4'h0, 32'h0);
    repeat (5) begin
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, 32'h20);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;

    // 6: reset during RESP after an MTIMECMP store committed
    @(posedge clk); #1 rsp_ready = 1'b0;
    req(A_CMP, 1'b1, 4'hF, 32'h5);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    chk("midrst_div4", d4_mtime, 64'h0);
    rsp_ready = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    req(A_CMP, 1'b0, 4'h0, 32'h0);
    req(A_CMP + 32'd4, 1'b0, 4'h0, 32'h0);
    repeat (20) @(negedge clk);
    chk("div4_final", d4_mtime, 64'(m4_cnt / 4));
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
